// File: rtl/alu_self_test_seq_if.sv
// Operand/result bus between the self-test sequencer, its vector ROM and the ALU.
// master = sequencer side, slave = ROM + ALU side.
interface alu_self_test_seq_if #(
    parameter int unsigned IDX_W = 4
);
    logic [IDX_W-1:0] vec_addr;
    logic [109:0]     vec_data;
    logic [31:0]      alu_A;
    logic [31:0]      alu_B;
    logic [3:0]       alu_code;
    logic [4:0]       alu_shamt;
    logic [31:0]      alu_result;
    logic [3:0]       alu_flags;

    modport master (
        output vec_addr, alu_A, alu_B, alu_code, alu_shamt,
        input  vec_data, alu_result, alu_flags
    );

    modport slave (
        input  vec_addr, alu_A, alu_B, alu_code, alu_shamt,
        output vec_data, alu_result, alu_flags
    );
endinterface

// File: rtl/alu_self_test_seq.sv
// ALU built-in self-test sequencer: steps through a vector ROM, drives the ALU
// operands and scores the ALU's result/flags against the stored expectations.
module alu_self_test_seq #(
    parameter int unsigned NUM_VEC = 12,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_self_test_seq_if.master  bus,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [IDX_W-1:0]     first_fail
);
    localparam int unsigned    ERR_W    = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  code;
        logic [4:0]  shamt;
        logic [31:0] exp_result;
        logic [3:0]  exp_flags;
        logic        chk_flags;
    } vec_t;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [31:0]      a_q, a_n, b_q, b_n;
    logic [3:0]       code_q, code_n;
    logic [4:0]       shamt_q, shamt_n;
    logic [31:0]      exp_result_q, exp_result_n;
    logic [3:0]       exp_flags_q, exp_flags_n;
    logic             chk_flags_q, chk_flags_n;
    logic             busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic [IDX_W-1:0] first_q, first_n;
    logic             seen_fail_q, seen_fail_n;
    vec_t             vec_c;
    logic             mismatch_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            code_q       <= '0;
            shamt_q      <= '0;
            exp_result_q <= '0;
            exp_flags_q  <= '0;
            chk_flags_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_q      <= '0;
            seen_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            a_q          <= a_n;
            b_q          <= b_n;
            code_q       <= code_n;
            shamt_q      <= shamt_n;
            exp_result_q <= exp_result_n;
            exp_flags_q  <= exp_flags_n;
            chk_flags_q  <= chk_flags_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
            pass_q       <= pass_n;
            err_q        <= err_n;
            first_q      <= first_n;
            seen_fail_q  <= seen_fail_n;
        end
    end

    // Next-state, scoring and registered-output next values
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        a_n          = a_q;
        b_n          = b_q;
        code_n       = code_q;
        shamt_n      = shamt_q;
        exp_result_n = exp_result_q;
        exp_flags_n  = exp_flags_q;
        chk_flags_n  = chk_flags_q;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        pass_n       = pass_q;
        err_n        = err_q;
        first_n      = first_q;
        seen_fail_n  = seen_fail_q;
        vec_c        = vec_t'(bus.vec_data);
        mismatch_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_n       = '0;
                    first_n     = '0;
                    pass_n      = 1'b0;
                    seen_fail_n = 1'b0;
                    idx_n       = '0;
                    busy_n      = 1'b1;
                    state_n     = LOAD;
                end
            end
            LOAD: begin
                a_n          = vec_c.a;
                b_n          = vec_c.b;
                code_n       = vec_c.code;
                shamt_n      = vec_c.shamt;
                exp_result_n = vec_c.exp_result;
                exp_flags_n  = vec_c.exp_flags;
                chk_flags_n  = vec_c.chk_flags;
                busy_n       = 1'b1;
                state_n      = CHECK;
            end
            CHECK: begin
                mismatch_c = (bus.alu_result != exp_result_q) ||
                             (chk_flags_q && (bus.alu_flags != exp_flags_q));
                if (mismatch_c) begin
                    if (err_q != ERR_MAX) begin
                        err_n = ERR_W'(err_q + 1'b1);
                    end
                    if (!seen_fail_q) begin
                        first_n = idx_q;
                    end
                    seen_fail_n = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                    state_n = DONE;
                end else begin
                    idx_n   = IDX_W'(idx_q + 1'b1);
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            DONE: begin
                // vec_addr reads 0 whenever the block is idle
                idx_n   = '0;
                state_n = IDLE;
            end
            default: begin
                idx_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.vec_addr  = idx_q;
    assign bus.alu_A     = a_q;
    assign bus.alu_B     = b_q;
    assign bus.alu_code  = code_q;
    assign bus.alu_shamt = shamt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_fail    = first_q;
endmodule

// File: tb/tb_alu_self_test_seq.sv
// Self-checking bench for alu_self_test_seq: three instances (12-vector with a
// behavioural ALU, 300-vector against a constant stub ALU, single-vector run).
module tb_alu_self_test_seq;
    localparam int unsigned N_M = 12;
    localparam int unsigned W_M = 4;
    localparam int unsigned N_S = 300;
    localparam int unsigned W_S = 9;
    localparam int unsigned N_O = 1;
    localparam int unsigned W_O = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start_m, start_s, start_o;

    always #5 clk = ~clk;

    alu_self_test_seq_if #(.IDX_W(W_M)) if_m ();
    alu_self_test_seq_if #(.IDX_W(W_S)) if_s ();
    alu_self_test_seq_if #(.IDX_W(W_O)) if_o ();

    logic             busy_m, done_m, pass_m, busy_s, done_s, pass_s, busy_o, done_o, pass_o;
    logic [7:0]       err_m, err_s, err_o;
    logic [W_M-1:0]   first_m;
    logic [W_S-1:0]   first_s;
    logic [W_O-1:0]   first_o;

    logic [109:0] rom_m [16];
    logic [109:0] rom_s [512];
    logic [109:0] rom_o [2];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural ALU: returns {fzero,fsign,fcarry,fequal,result}
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] code, input logic [4:0] sh);
        logic [32:0] sum;
        logic [31:0] r;
        logic        c;
        c = 1'b0;
        case (code)
            4'd0:  r = a;
            4'd1:  begin sum = {1'b0, a} + {1'b0, b}; r = sum[31:0]; c = sum[32]; end
            4'd2:  r = a - b;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = b << sh;
            4'd7:  r = b >> sh;
            4'd8:  r = 32'($signed(b) >>> sh);
            4'd9:  r = b << a[4:0];
            4'd10: r = b >> a[4:0];
            4'd11: r = 32'($signed(b) >>> a[4:0]);
            default: r = ~(a | b);
        endcase
        return {(r == 32'd0), r[31], c, (a == b), r};
    endfunction

    assign {if_m.alu_flags, if_m.alu_result} = alu_ref(if_m.alu_A, if_m.alu_B, if_m.alu_code, if_m.alu_shamt);
    assign {if_o.alu_flags, if_o.alu_result} = alu_ref(if_o.alu_A, if_o.alu_B, if_o.alu_code, if_o.alu_shamt);
    assign if_s.alu_result = 32'hDEADBEEF;
    assign if_s.alu_flags  = 4'h0;
    assign if_m.vec_data   = rom_m[if_m.vec_addr];
    assign if_s.vec_data   = rom_s[if_s.vec_addr];
    assign if_o.vec_data   = rom_o[if_o.vec_addr];

    alu_self_test_seq #(.NUM_VEC(N_M), .IDX_W(W_M)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .bus(if_m), .start(start_m), .busy(busy_m),
        .done(done_m), .pass(pass_m), .err_count(err_m), .first_fail(first_m));
    alu_self_test_seq #(.NUM_VEC(N_S), .IDX_W(W_S)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s), .start(start_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .err_count(err_s), .first_fail(first_s));
    alu_self_test_seq #(.NUM_VEC(N_O), .IDX_W(W_O)) u_dut_o (
        .clk(clk), .rst_n(rst_n), .bus(if_o), .start(start_o), .busy(busy_o),
        .done(done_o), .pass(pass_o), .err_count(err_o), .first_fail(first_o));

    // Observation mux over the instance under test
    int         sel = 0;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_err;
    logic [8:0] o_first, o_addr;
    always_comb begin
        o_busy = busy_m; o_done = done_m; o_pass = pass_m; o_err = err_m;
        o_first = 9'(first_m); o_addr = 9'(if_m.vec_addr);
        if (sel == 1) begin
            o_busy = busy_s; o_done = done_s; o_pass = pass_s; o_err = err_s;
            o_first = 9'(first_s); o_addr = 9'(if_s.vec_addr);
        end else if (sel == 2) begin
            o_busy = busy_o; o_done = done_o; o_pass = pass_o; o_err = err_o;
            o_first = 9'(first_o); o_addr = 9'(if_o.vec_addr);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: start_m = v;
            1: start_s = v;
            default: start_o = v;
        endcase
    endtask

    function automatic logic [109:0] rand_vec(input logic [3:0] code);
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [35:0] r;
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        sh = 5'($urandom);
        r  = alu_ref(a, b, code, sh);
        return {a, b, code, sh, r[31:0], r[35:32], 1'($urandom)};
    endfunction

    function automatic logic [109:0] rom_word(input int which, input int i);
        if (which == 0) return rom_m[i];
        if (which == 1) return rom_s[i];
        return rom_o[i];
    endfunction

    // Reference outcome of a whole run, computed vector by vector
    task automatic predict(input int which, input int n, output int e, output int f, output logic p);
        logic [109:0] v;
        logic [35:0]  act;
        logic         mm, seen;
        e = 0; f = 0; seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            v   = rom_word(which, i);
            act = (which == 1) ? {4'h0, 32'hDEADBEEF} : alu_ref(v[109:78], v[77:46], v[45:42], v[41:37]);
            mm  = (act[31:0] != v[36:5]) || (v[0] && (act[35:32] != v[4:1]));
            if (mm) begin
                if (!seen) f = i;
                seen = 1'b1;
                e++;
            end
        end
        if (e > 255) e = 255;
        p = (e == 0);
    endtask

    // One complete run; mid = cycle at which a stray start pulse is applied (-1: none)
    task automatic run(input string tag, input int which, input int n, input int mid);
        int   e, f, busy_cnt, done_cnt, done_cyc;
        logic p;
        sel = which;
        predict(which, n, e, f, p);
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        @(negedge clk); set_start(which, 1'b1);
        for (int cyc = 1; cyc <= 2 * n + 4; cyc++) begin
            @(negedge clk);
            set_start(which, cyc == mid);
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq({tag, ".err_count"}, 32'(o_err), 32'(e));
                check_eq({tag, ".first_fail"}, 32'(o_first), 32'(f));
                check_eq({tag, ".pass"}, 32'(o_pass), 32'(p));
            end
        end
        set_start(which, 1'b0);
        check_eq({tag, ".done_count"}, 32'(done_cnt), 32'd1);
        check_eq({tag, ".done_cycle"}, 32'(done_cyc), 32'(2 * n + 1));
        check_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(2 * n));
        check_eq({tag, ".idle_addr"}, 32'(o_addr), 32'd0);
        check_eq({tag, ".pass_held"}, 32'(o_pass), 32'(p));
    endtask

    task automatic fill_main_ordered();
        for (int i = 0; i < N_M; i++) rom_m[i] = rand_vec(4'(i));
    endtask

    initial begin
        int done_seen;
        logic [109:0] v;
        rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; start_o = 1'b0;
        for (int i = 0; i < 16; i++) rom_m[i] = rand_vec(4'(i));
        for (int i = 0; i < 512; i++) rom_s[i] = rand_vec(4'(i));
        rom_o[0] = {32'd12, 32'd11, 4'b0001, 5'd0, 32'd23, 4'h0, 1'b0};
        rom_o[1] = rom_o[0];
        repeat (3) @(negedge clk);
        check_eq("rst.outputs_m", 32'({if_m.vec_addr, if_m.alu_code, if_m.alu_shamt, busy_m, done_m,
                                        pass_m, err_m, first_m}), 32'd0);
        check_eq("rst.alu_A_m", if_m.alu_A, 32'd0);
        check_eq("rst.alu_B_o", if_o.alu_B, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle.outputs_m", 32'({if_m.vec_addr, busy_m, done_m, pass_m, err_m, first_m}), 32'd0);

        run("one_vec", 2, N_O, -1);
        check_eq("one_vec.alu_A_hold", if_o.alu_A, 32'd12);

        fill_main_ordered();
        run("full_clean", 0, N_M, 7);

        rom_m[3][36:5] = rom_m[3][36:5] + 32'd1;
        rom_m[7][36:5] = rom_m[7][36:5] ^ 32'h0000_0100;
        run("corrupt_3_7", 0, N_M, -1);

        fill_main_ordered();
        v = rom_m[4];
        v[4] = ~v[4];
        v[0] = 1'b0;
        rom_m[4] = v;
        run("fzero_nochk", 0, N_M, -1);
        v[0] = 1'b1;
        rom_m[4] = v;
        run("fzero_chk", 0, N_M, -1);

        fill_main_ordered();
        rom_m[3][36:5] = ~rom_m[3][36:5];
        rom_m[7][36:5] = ~rom_m[7][36:5];
        sel = 0;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        repeat (11) @(negedge clk);
        check_eq("rst_mid.err_before", 32'(o_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid.outputs", 32'({if_m.vec_addr, if_m.alu_code, if_m.alu_shamt, busy_m, done_m,
                                         pass_m, err_m, first_m}), 32'd0);
        check_eq("rst_mid.alu_A", if_m.alu_A, 32'd0);
        done_seen = 0;
        repeat (3) begin @(negedge clk); if (done_m) done_seen++; end
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (done_m) done_seen++; end
        check_eq("rst_mid.no_done", 32'(done_seen), 32'd0);
        check_eq("rst_mid.idle_busy", 32'(busy_m), 32'd0);
        fill_main_ordered();
        run("after_rst", 0, N_M, 2 * N_M + 1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N_M; i++) begin
                v = rand_vec(4'($urandom));
                if ($urandom_range(0, 4) == 0) v[5 + $urandom_range(0, 31)] ^= 1'b1;
                if ($urandom_range(0, 4) == 0) v[1 + $urandom_range(0, 3)] ^= 1'b1;
                rom_m[i] = v;
            end
            run($sformatf("rand%0d", r), 0, N_M, $urandom_range(1, 2 * N_M + 1));
        end

        for (int i = 0; i < N_S; i++) begin
            v = rand_vec(4'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                v[36:5] = 32'hDEADBEEF;
                v[4:1]  = 4'h0;
            end else if (v[36:5] == 32'hDEADBEEF) begin
                v[36:5] = 32'h0;
            end
            rom_s[i] = v;
        end
        run("saturate", 1, N_S, 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
